move_paddle_array: RTL and testbench

Parametrised multi-paddle position controller for the Pong datapath. Tracks NUM_PADDLES independent paddles, each driven by an active-low up/down button pair. Adds a step-rate prescaler, hold-to-accelerate mode, bounded saturation with limit flags, and global freeze and recentre controls. Sits between the debounced button inputs and the renderer/collision logic, which consume the packed X/Y position buses.

---
 rtl/move_paddle_array.sv | 127 ++++++++++++
 tb/tb_move_paddle_array.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/move_paddle_array.sv
// Multi-paddle Y position controller with a step prescaler,
// hold-to-accelerate, clamped limits, and freeze and recentre controls.
module move_paddle_array #(
  parameter int NUM_PADDLES = 2,
  parameter int X_WIDTH     = 8,
  parameter int Y_WIDTH     = 9,
  parameter logic [NUM_PADDLES*X_WIDTH-1:0] X_POSITIONS = {8'd150, 8'd10},
  parameter int Y_MIN       = 185,
  parameter int Y_MAX       = 305,
  parameter int Y_RESET     = 240,
  parameter int STEP_DIV    = 4,
  parameter int ACCEL_STEPS = 8,
  parameter int FAST_STEP   = 4
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [2*NUM_PADDLES-1:0]       button,
  input  logic                           freeze,
  input  logic                           recentre,
  output logic [NUM_PADDLES*X_WIDTH-1:0] paddleXValue,
  output logic [NUM_PADDLES*Y_WIDTH-1:0] paddleYValue,
  output logic [NUM_PADDLES-1:0]         atTop,
  output logic [NUM_PADDLES-1:0]         atBottom
);

  typedef enum logic [1:0] {IDLE, SLOW, FAST} state_t;

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int CW = $clog2(ACCEL_STEPS + 2);
  localparam int YW = Y_WIDTH + 1;

  assign paddleXValue = X_POSITIONS;

  for (genvar i = 0; i < NUM_PADDLES; i++) begin : gChan
    state_t             stateQ, stateD;
    logic               dirQ, dirD;
    logic [PW-1:0]      prescQ, prescD;
    logic [CW-1:0]      cntQ, cntD;
    logic [Y_WIDTH-1:0] yQ, yD;
    logic               topQ, botQ;
    logic               up, dn, press, stepEn;
    logic [YW-1:0]      stepSize, yExt, yNext;

    assign up    = ~button[2*i+1] & button[2*i];
    assign dn    = button[2*i+1] & ~button[2*i];
    assign press = up | dn;
    assign yExt  = {1'b0, yQ};

    always_comb begin
      stateD   = stateQ;
      dirD     = dirQ;
      prescD   = prescQ;
      cntD     = cntQ;
      stepEn   = 1'b0;
      stepSize = YW'(1);
      if (press && (stateQ == IDLE || up != dirQ)) begin
        // fresh press or reversal: immediate single-pixel step
        stepEn = 1'b1;
        dirD   = up;
        prescD = '0;
        cntD   = CW'(1);
        stateD = (ACCEL_STEPS == 1) ? FAST : SLOW;
      end else if (stateQ != IDLE) begin
        if (!press) begin
          stateD = IDLE;
          prescD = '0;
          cntD   = '0;
        end else if (prescQ == PW'(STEP_DIV - 1)) begin
          stepEn = 1'b1;
          prescD = '0;
          if (stateQ == FAST) begin
            stepSize = YW'(FAST_STEP);
          end else if (ACCEL_STEPS != 0) begin
            cntD = cntQ + 1'b1;
            if (cntD == CW'(ACCEL_STEPS)) stateD = FAST;
          end
        end else begin
          prescD = prescQ + 1'b1;
        end
      end
    end

    always_comb begin
      if (dirD) begin
        if (yExt < stepSize + YW'(Y_MIN)) yNext = YW'(Y_MIN);
        else yNext = yExt - stepSize;
      end else begin
        if (yExt + stepSize > YW'(Y_MAX)) yNext = YW'(Y_MAX);
        else yNext = yExt + stepSize;
      end
      yD = stepEn ? yNext[Y_WIDTH-1:0] : yQ;
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        stateQ <= IDLE;
        dirQ   <= 1'b0;
        prescQ <= '0;
        cntQ   <= '0;
        yQ     <= Y_WIDTH'(Y_RESET);
        topQ   <= 1'b0;
        botQ   <= 1'b0;
      end else if (recentre) begin
        stateQ <= IDLE;
        dirQ   <= 1'b0;
        prescQ <= '0;
        cntQ   <= '0;
        yQ     <= Y_WIDTH'(Y_RESET);
        topQ   <= 1'b0;
        botQ   <= 1'b0;
      end else if (!freeze) begin
        stateQ <= stateD;
        dirQ   <= dirD;
        prescQ <= prescD;
        cntQ   <= cntD;
        yQ     <= yD;
        topQ   <= (yD == Y_WIDTH'(Y_MIN));
        botQ   <= (yD == Y_WIDTH'(Y_MAX));
      end
    end

    assign paddleYValue[i*Y_WIDTH +: Y_WIDTH] = yQ;
    assign atTop[i]    = topQ;
    assign atBottom[i] = botQ;
  end

endmodule

// File: tb/tb_move_paddle_array.sv
// Directed bench for move_paddle_array with the default two paddles.
module tb_move_paddle_array;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  button;
  logic        freeze;
  logic        recentre;
  logic [15:0] paddleXValue;
  logic [17:0] paddleYValue;
  logic [1:0]  atTop;
  logic [1:0]  atBottom;

  int passCnt = 0;
  int failCnt = 0;
  int total   = 0;

  move_paddle_array dut (
    .clock        (clock),
    .reset        (reset),
    .button       (button),
    .freeze       (freeze),
    .recentre     (recentre),
    .paddleXValue (paddleXValue),
    .paddleYValue (paddleYValue),
    .atTop        (atTop),
    .atBottom     (atBottom)
  );

  always #5 clock = ~clock;

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] y0();
    return {23'd0, paddleYValue[8:0]};
  endfunction

  function automatic logic [31:0] y1();
    return {23'd0, paddleYValue[17:9]};
  endfunction

  initial begin
    reset    = 1'b1;
    button   = 4'b1111;
    freeze   = 1'b0;
    recentre = 1'b0;
    cyc(2);
    reset = 1'b0;
    check("rst_y0", y0(), 240);
    check("rst_y1", y1(), 240);
    check("rst_x", {16'd0, paddleXValue}, {16'd0, 8'd150, 8'd10});
    check("rst_top", {30'd0, atTop}, 0);
    check("rst_bot", {30'd0, atBottom}, 0);

    button = 4'b1101;
    cyc(1);
    button = 4'b1111;
    check("tap_y0", y0(), 239);
    check("tap_y1", y1(), 240);
    cyc(3);
    check("tap_hold", y0(), 239);

    button = 4'b1101;
    cyc(1);
    check("up_e1", y0(), 238);
    cyc(28);
    check("up_slow8", y0(), 231);
    cyc(3);
    check("up_gap", y0(), 231);
    cyc(1);
    check("up_fast1", y0(), 227);
    cyc(40);
    check("up_e73", y0(), 187);
    check("up_top0", {31'd0, atTop[0]}, 0);
    cyc(4);
    check("up_clamp", y0(), 185);
    check("up_top1", {31'd0, atTop[0]}, 1);
    cyc(8);
    check("up_stay", y0(), 185);
    button = 4'b1111;
    cyc(1);
    check("up_rel_top", {31'd0, atTop[0]}, 1);

    button = 4'b0011;
    cyc(50);
    check("both_y1", y1(), 240);
    button = 4'b1011;
    cyc(1);
    check("dn_e1", y1(), 241);
    cyc(84);
    check("dn_e85", y1(), 304);
    check("dn_bot0", {31'd0, atBottom[1]}, 0);
    cyc(4);
    check("dn_clamp", y1(), 305);
    check("dn_bot1", {31'd0, atBottom[1]}, 1);
    cyc(10);
    check("dn_stay", y1(), 305);
    check("dn_indep", y0(), 185);

    button = 4'b1110;
    cyc(3);
    check("fz_pre", y0(), 186);
    freeze = 1'b1;
    cyc(20);
    check("fz_hold", y0(), 186);
    freeze = 1'b0;
    cyc(1);
    check("fz_phase", y0(), 186);
    cyc(1);
    check("fz_step", y0(), 187);
    cyc(28);
    check("fz_fast", y0(), 197);

    recentre = 1'b1;
    cyc(1);
    recentre = 1'b0;
    check("rc_y0", y0(), 240);
    check("rc_y1", y1(), 240);
    check("rc_bot", {30'd0, atBottom}, 0);
    cyc(1);
    check("rc_fresh", y0(), 241);
    cyc(4);
    check("pre_arst", y0(), 242);

    #2 reset = 1'b1;
    #1;
    check("arst_y0", y0(), 240);
    check("arst_flags", {30'd0, atTop | atBottom}, 0);
    button = 4'b1111;
    reset  = 1'b0;
    cyc(2);
    check("post_arst", y0(), 240);

    $display("%0d/%0d checks passed", passCnt, total);
    $finish;
  end

endmodule
